// File: rtl/multiplicador_param_sat_pkg.sv
// Shared definitions for the parametrised shift-and-add multiplier family:
// FSM state encoding and the counter-width helper.
package multiplicador_param_sat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Ceiling log2, used as clog2(WIDTH+1) so the counter can hold WIDTH.
  function automatic int clog2(input int value);
    int res_v;
    res_v = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res_v = i + 1;
      end
    end
    return res_v;
  endfunction

endpackage

// File: rtl/multiplicador_param_sat_saturador.sv
// Combinational clamp of a 2*WIDTH-bit product into WIDTH bits, unsigned or
// two's-complement, with an overflow flag. Shared with other ALU operations.
module saturador_param
  import multiplicador_param_sat_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] produto,
  input  logic               sinal,
  output logic [WIDTH-1:0]   valor,
  output logic               overflow
);

  localparam logic [WIDTH-1:0] MAX_U = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_S = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] upper_s;

  assign upper_s = produto[2*WIDTH-1:WIDTH-1];

  // A signed value fits when its top WIDTH+1 bits are pure sign extension.
  always_comb begin
    valor    = produto[WIDTH-1:0];
    overflow = 1'b0;
    if (sinal) begin
      if ((&upper_s) || (~|upper_s)) begin
        valor    = produto[WIDTH-1:0];
        overflow = 1'b0;
      end else begin
        valor    = produto[2*WIDTH-1] ? MIN_S : MAX_S;
        overflow = 1'b1;
      end
    end else begin
      if (|produto[2*WIDTH-1:WIDTH]) begin
        valor    = MAX_U;
        overflow = 1'b1;
      end else begin
        valor    = produto[WIDTH-1:0];
        overflow = 1'b0;
      end
    end
  end

endmodule

// File: rtl/multiplicador_param_sat.sv
// Sequential shift-and-add multiplier with fixed WIDTH+1 latency, signed or
// unsigned operands, and saturated plus full-width registered results.
module multiplicador_param_sat
  import multiplicador_param_sat_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 SINAL,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     Resultado,
  output logic [2*WIDTH-1:0]   Produto,
  output logic                 Overflow,
  output logic                 Pronto,
  output logic                 Ocupado
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_CW    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      ZERO_CW   = {CW{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W    = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ZERO_2W   = {(2*WIDTH){1'b0}};

  state_e             state_r, state_n;
  logic [2*WIDTH-1:0] mcand_r, acc_r, fixed_s;
  logic [WIDTH-1:0]   mplier_r, mag_a_s, mag_b_s, sat_val_s;
  logic [CW-1:0]      cnt_r;
  logic               neg_r, sinal_r, accept_s, sat_ovf_s;

  // Operand magnitudes; |-2^(WIDTH-1)| is representable as an unsigned WIDTH-bit value.
  always_comb begin
    mag_a_s = A;
    mag_b_s = B;
    if (SINAL && A[WIDTH-1]) begin
      mag_a_s = (~A) + ONE_W;
    end else begin
      mag_a_s = A;
    end
    if (SINAL && B[WIDTH-1]) begin
      mag_b_s = (~B) + ONE_W;
    end else begin
      mag_b_s = B;
    end
  end

  assign fixed_s = neg_r ? ((~acc_r) + ONE_2W) : acc_r;

  saturador_param #(.WIDTH(WIDTH)) u_sat (
    .produto  (fixed_s),
    .sinal    (sinal_r),
    .valor    (sat_val_s),
    .overflow (sat_ovf_s)
  );

  // Next-state logic; START is only honoured in IDLE or DONE.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          accept_s = 1'b1;
          state_n  = ST_CALC;
        end else begin
          state_n  = state_r;
        end
      end
      ST_CALC: begin
        if (cnt_r == LAST_ITER) begin
          state_n = ST_FIX;
        end else begin
          state_n = ST_CALC;
        end
      end
      ST_FIX:  state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath: operand latch, one add-and-shift per CALC cycle, sign fix and saturation in FIX.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      mcand_r   <= ZERO_2W;
      mplier_r  <= ZERO_W;
      acc_r     <= ZERO_2W;
      cnt_r     <= ZERO_CW;
      neg_r     <= 1'b0;
      sinal_r   <= 1'b0;
      Produto   <= ZERO_2W;
      Resultado <= ZERO_W;
      Overflow  <= 1'b0;
      Pronto    <= 1'b0;
      Ocupado   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            mcand_r  <= {ZERO_W, mag_a_s};
            mplier_r <= mag_b_s;
            acc_r    <= ZERO_2W;
            cnt_r    <= ZERO_CW;
            neg_r    <= SINAL & (A[WIDTH-1] ^ B[WIDTH-1]);
            sinal_r  <= SINAL;
            Overflow <= 1'b0;
            Pronto   <= 1'b0;
            Ocupado  <= 1'b1;
          end
        end
        ST_CALC: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + ONE_CW;
        end
        ST_FIX: begin
          Produto   <= fixed_s;
          Resultado <= sat_val_s;
          Overflow  <= sat_ovf_s;
          Pronto    <= 1'b1;
          Ocupado   <= 1'b0;
        end
        default: begin
          Ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_param_sat.sv
// Scoreboard bench for multiplicador_param_sat at WIDTH 8, 4 and 16: an
// arithmetic reference model feeds per-instance queues that a monitor drains.
module tb_multiplicador_param_sat;

  localparam int NI = 3;

  typedef struct {
    logic [63:0] prod;
    logic [31:0] res;
    bit          ovf;
    int          issue;
  } exp_t;

  typedef struct {
    string       name;
    int          inst;
    bit          chk_data;
    logic [63:0] prod;
    logic [31:0] res;
    bit          ovf;
    bit          pronto;
    bit          ocup;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [NI];
  logic        sinal_v [NI];
  logic [31:0] a_v [NI];
  logic [31:0] b_v [NI];

  logic [7:0]  res0;
  logic [15:0] prod0;
  logic [3:0]  res1;
  logic [7:0]  prod1;
  logic [15:0] res2;
  logic [31:0] prod2;
  logic [31:0] res_x [NI];
  logic [63:0] prod_x [NI];
  logic        ovf_x [NI];
  logic        pronto_x [NI];
  logic        ocup_x [NI];
  logic        pronto_prev [NI];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  exp_t  exp_q [NI][$];
  snap_t snap_q [$];

  multiplicador_param_sat #(.WIDTH(8)) dut8 (
    .CLOCK(clk), .RESET(rst_n), .START(start_v[0]), .SINAL(sinal_v[0]),
    .A(a_v[0][7:0]), .B(b_v[0][7:0]), .Resultado(res0), .Produto(prod0),
    .Overflow(ovf_x[0]), .Pronto(pronto_x[0]), .Ocupado(ocup_x[0]));

  multiplicador_param_sat #(.WIDTH(4)) dut4 (
    .CLOCK(clk), .RESET(rst_n), .START(start_v[1]), .SINAL(sinal_v[1]),
    .A(a_v[1][3:0]), .B(b_v[1][3:0]), .Resultado(res1), .Produto(prod1),
    .Overflow(ovf_x[1]), .Pronto(pronto_x[1]), .Ocupado(ocup_x[1]));

  multiplicador_param_sat #(.WIDTH(16)) dut16 (
    .CLOCK(clk), .RESET(rst_n), .START(start_v[2]), .SINAL(sinal_v[2]),
    .A(a_v[2][15:0]), .B(b_v[2][15:0]), .Resultado(res2), .Produto(prod2),
    .Overflow(ovf_x[2]), .Pronto(pronto_x[2]), .Ocupado(ocup_x[2]));

  assign res_x[0]  = {24'd0, res0};
  assign prod_x[0] = {48'd0, prod0};
  assign res_x[1]  = {28'd0, res1};
  assign prod_x[1] = {56'd0, prod1};
  assign res_x[2]  = {16'd0, res2};
  assign prod_x[2] = {32'd0, prod2};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  // Reference: integer product of the operands as read in the chosen mode, then clamp.
  function automatic exp_t model(input int w, input bit s, input logic [31:0] a,
                                 input logic [31:0] b, input int issue);
    exp_t   e;
    longint mw, ma, mb, p, lo, hi, c;
    mw = (longint'(1) << w) - 1;
    ma = longint'(a) & mw;
    mb = longint'(b) & mw;
    if (s && ma >= (longint'(1) << (w - 1))) ma = ma - (longint'(1) << w);
    if (s && mb >= (longint'(1) << (w - 1))) mb = mb - (longint'(1) << w);
    p = ma * mb;
    if (s) begin
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
    end else begin
      hi = mw;
      lo = 0;
    end
    c = p;
    if (p > hi) c = hi;
    if (p < lo) c = lo;
    e.prod  = 64'(p & ((longint'(1) << (2 * w)) - 1));
    e.res   = 32'(c & mw);
    e.ovf   = (c != p);
    e.issue = issue;
    return e;
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d (W=%0d): got %0h, required %0h", name, i, wid(i), act, exp);
    end
  endtask

  task automatic snap(input string name, input int i, input bit chk_data, input logic [63:0] prod,
                      input logic [31:0] res, input bit ovf, input bit pronto, input bit ocup);
    snap_t s;
    s.name = name; s.inst = i; s.chk_data = chk_data; s.prod = prod;
    s.res = res; s.ovf = ovf; s.pronto = pronto; s.ocup = ocup;
    snap_q.push_back(s);
  endtask

  // Monitor: compares each Pronto rise against the scoreboard and drains snapshot checks.
  initial begin : monitor
    exp_t  e;
    snap_t s;
    for (int i = 0; i < NI; i++) pronto_prev[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (pronto_x[i] === 1'b1 && pronto_prev[i] === 1'b0) begin
          if (exp_q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pronto inst%0d: got a result, required none outstanding", i);
          end else begin
            e = exp_q[i].pop_front();
            chk("produto", i, prod_x[i], e.prod);
            chk("resultado", i, {32'd0, res_x[i]}, {32'd0, e.res});
            chk("overflow", i, {63'd0, ovf_x[i]}, {63'd0, e.ovf});
            chk("latency", i, 64'(cyc - e.issue), 64'(wid(i) + 1));
          end
        end else if (exp_q[i].size() > 0) begin
          if (cyc > exp_q[i][0].issue + wid(i) + 4) begin
            total++;
            bad++;
            $display("FAIL timeout inst%0d: got no Pronto by cycle %0d, required by cycle %0d",
                     i, cyc, exp_q[i][0].issue + wid(i) + 1);
            void'(exp_q[i].pop_front());
          end
        end
        pronto_prev[i] = pronto_x[i];
      end
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk({s.name, "_pronto"}, s.inst, {63'd0, pronto_x[s.inst]}, {63'd0, s.pronto});
        chk({s.name, "_ocupado"}, s.inst, {63'd0, ocup_x[s.inst]}, {63'd0, s.ocup});
        chk({s.name, "_overflow"}, s.inst, {63'd0, ovf_x[s.inst]}, {63'd0, s.ovf});
        if (s.chk_data) begin
          chk({s.name, "_produto"}, s.inst, prod_x[s.inst], s.prod);
          chk({s.name, "_resultado"}, s.inst, {32'd0, res_x[s.inst]}, {32'd0, s.res});
        end
      end
    end
  end

  task automatic run_op(input int i, input bit s, input logic [31:0] a, input logic [31:0] b,
                        input bit track);
    @(negedge clk);
    a_v[i] = a; b_v[i] = b; sinal_v[i] = s; start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    if (track) exp_q[i].push_back(model(wid(i), s, a, b, cyc));
    a_v[i] = $urandom; b_v[i] = $urandom; sinal_v[i] = ~s;
  endtask

  task automatic wait_done(input int i);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (pronto_x[i] === 1'b1) break;
    end
  endtask

  task automatic back_to_back(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a_v[i] = $urandom; b_v[i] = $urandom; sinal_v[i] = k[0]; start_v[i] = 1'b1;
      @(posedge clk);
      #1;
      exp_q[i].push_back(model(wid(i), sinal_v[i], a_v[i], b_v[i], cyc));
      if (k < n - 1) repeat (wid(i) + 1) @(posedge clk);
    end
    start_v[i] = 1'b0;
    wait_done(i);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] corner [5];
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; sinal_v[i] = 1'b0; a_v[i] = 32'd0; b_v[i] = 32'd0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) snap("reset_state", i, 1'b1, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed WIDTH=8 cases.
    run_op(0, 1'b0, 32'd15, 32'd17, 1'b1);
    wait_done(0);
    repeat (3) @(posedge clk);
    #1;
    snap("hold_done", 0, 1'b1, 64'd255, 32'd255, 1'b0, 1'b1, 1'b0);
    run_op(0, 1'b0, 32'd16, 32'd16, 1'b1);   wait_done(0);
    run_op(0, 1'b0, 32'd0, 32'd200, 1'b1);   wait_done(0);
    run_op(0, 1'b1, 32'hFD, 32'd5, 1'b1);    wait_done(0);
    run_op(0, 1'b1, 32'hF0, 32'd8, 1'b1);    wait_done(0);
    run_op(0, 1'b1, 32'h80, 32'h80, 1'b1);   wait_done(0);
    run_op(0, 1'b1, 32'd127, 32'hFE, 1'b1);  wait_done(0);

    // START pulsed and operands changed while busy must not disturb 7x9.
    run_op(0, 1'b0, 32'd7, 32'd9, 1'b1);
    @(posedge clk);
    #1;
    a_v[0] = 32'd1; b_v[0] = 32'd1; start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0; a_v[0] = 32'd200; b_v[0] = 32'd3;
    snap("busy_ignores_start", 0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    wait_done(0);
    repeat (4) @(posedge clk);

    // Reset during iteration 4 clears everything at once.
    run_op(0, 1'b0, 32'd5, 32'd6, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    snap("reset_midop", 0, 1'b1, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 32'd3, 32'd3, 1'b1);
    wait_done(0);

    for (int k = 0; k < 150; k++) begin
      run_op(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
      wait_done(0);
    end

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_op(1, s[0], 32'(a), 32'(b), 1'b1);
          wait_done(1);
        end
      end
    end

    corner[0] = 32'h0000; corner[1] = 32'h8000; corner[2] = 32'h7FFF;
    corner[3] = 32'hFFFF; corner[4] = 32'h0001;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      run_op(2, 1'($urandom_range(0, 1)), a, b, 1'b1);
      wait_done(2);
    end

    for (int i = 0; i < NI; i++) back_to_back(i, 4);

    repeat (40) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
